microwave_timer: RTL and testbench



---
 rtl/microondas_pkg.sv | 32 +++
 rtl/mmss_bcd_countdown.sv | 59 +++++
 rtl/microwave_timer.sv | 190 +++++++++++++++++++
 tb/tb_microwave_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : microondas_pkg
//  Purpose  : Shared types and constants for the microwave countdown timer:
//             FSM state encoding, BCD digit width and digit limits.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package microondas_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

  // IDLE: time 00:00; SET: time nonzero, stopped; RUN: counting; DONE: expired
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } mmss_t;

endpackage : microondas_pkg
`default_nettype wire

// File: rtl/mmss_bcd_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : mmss_bcd_countdown
//  Purpose  : Combinational one-second decrement of a BCD MM:SS value with a
//             borrow chain (sec_ones 0->9, sec_tens 0->5, min_ones 0->9,
//             min_tens decrements). Also flags 00:01 and 00:00.
//  Ports    : min_tens_i/min_ones_i/sec_tens_i/sec_ones_i  current digits
//             min_tens_o/min_ones_o/sec_tens_o/sec_ones_o  decremented digits
//             is_one_o   time == 00:01
//             is_zero_o  time == 00:00
//  Revision : 1.0  initial release
// ============================================================================
module mmss_bcd_countdown
  import microondas_pkg::*;
(
  input  logic [BCD_W-1:0] min_tens_i,
  input  logic [BCD_W-1:0] min_ones_i,
  input  logic [BCD_W-1:0] sec_tens_i,
  input  logic [BCD_W-1:0] sec_ones_i,
  output logic [BCD_W-1:0] min_tens_o,
  output logic [BCD_W-1:0] min_ones_o,
  output logic [BCD_W-1:0] sec_tens_o,
  output logic [BCD_W-1:0] sec_ones_o,
  output logic             is_one_o,
  output logic             is_zero_o
);

  logic w_borrow_so;
  logic w_borrow_st;
  logic w_borrow_mo;

  always_comb begin
    w_borrow_so = (sec_ones_i == '0);
    w_borrow_st = w_borrow_so && (sec_tens_i == '0);
    w_borrow_mo = w_borrow_st && (min_ones_i == '0);

    sec_ones_o = w_borrow_so ? DIGIT_MAX : (sec_ones_i - 4'd1);

    // sec_tens only moves when sec_ones borrows; values above 5 entered from
    // the keypad simply count down through the tens like any other digit.
    sec_tens_o = sec_tens_i;
    if (w_borrow_so) begin
      sec_tens_o = (sec_tens_i == '0) ? SEC_TENS_MAX : (sec_tens_i - 4'd1);
    end

    min_ones_o = min_ones_i;
    if (w_borrow_st) begin
      min_ones_o = (min_ones_i == '0) ? DIGIT_MAX : (min_ones_i - 4'd1);
    end

    // Never reached from 00:00 in use: the caller stops counting there.
    min_tens_o = w_borrow_mo ? (min_tens_i - 4'd1) : min_tens_i;

    is_zero_o = ({min_tens_i, min_ones_i, sec_tens_i, sec_ones_i} == 16'h0000);
    is_one_o  = ({min_tens_i, min_ones_i, sec_tens_i, sec_ones_i} == 16'h0001);
  end

endmodule : mmss_bcd_countdown
`default_nettype wire

// File: rtl/microwave_timer.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_timer
//  Purpose  : Magnetron set/reset latch plus 4-digit BCD MM:SS countdown.
//             Keypad digits shift in from the right; S starts, R pauses,
//             clear zeroes everything. timer_done rises on the edge the count
//             reaches 00:00.
//  Build    : define DONE_BEEP_EN to enable the done buzzer (beep high for
//             BEEP_SECS*TICKS_PER_SEC cycles); otherwise beep is tied low.
//  Ports    : clk, rst (sync, active high)
//             S, R        magnetron latch set / reset requests
//             clear       sync clear: zero time, stop, drop done
//             key_valid   one-cycle keypad strobe, key_digit 0-9 accepted
//             mag_on      magnetron enable (state RUN)
//             timer_done  countdown reached 00:00
//             min_tens, min_ones, sec_tens, sec_ones  BCD display digits
//             beep        done buzzer
//  Revision : 1.0  initial release
// ============================================================================
module microwave_timer
  import microondas_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  input  logic             R,
  input  logic             clear,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  output logic             mag_on,
  output logic             timer_done,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             beep
);

  localparam int PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  if ((TICKS_PER_SEC < 2) || (BEEP_SECS < 1)) begin : g_bad_params
    $error("microwave_timer: TICKS_PER_SEC must be >= 2 and BEEP_SECS >= 1");
  end

  state_e               state_q, state_d;
  mmss_t                time_q, time_d;
  mmss_t                time_dec;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 done_q, done_d;
  logic                 mag_on_q;
  logic                 is_one;
  logic                 is_zero;
  logic                 key_ok;
  logic                 key_take;
  logic                 done_entry;
  logic                 tick;

  mmss_bcd_countdown u_countdown (
    .min_tens_i (time_q.min_tens),
    .min_ones_i (time_q.min_ones),
    .sec_tens_i (time_q.sec_tens),
    .sec_ones_i (time_q.sec_ones),
    .min_tens_o (time_dec.min_tens),
    .min_ones_o (time_dec.min_ones),
    .sec_tens_o (time_dec.sec_tens),
    .sec_ones_o (time_dec.sec_ones),
    .is_one_o   (is_one),
    .is_zero_o  (is_zero)
  );

  assign key_ok = key_valid && (key_digit <= DIGIT_MAX);
  assign tick   = (presc_q == PRESC_LAST);

  // Priority: clear > R > tick > S > key entry (rst handled in the flops).
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    presc_d    = presc_q;
    done_d     = done_q;
    key_take   = 1'b0;
    done_entry = 1'b0;

    if (clear) begin
      state_d = IDLE;
      time_d  = '0;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (state_q == RUN) begin
      if (R) begin
        // Pause: digits and prescaler hold, prescaler restarts on next S.
        state_d = SET;
      end else if (tick) begin
        presc_d = '0;
        time_d  = time_dec;
        if (is_one) begin
          state_d    = DONE;
          done_d     = 1'b1;
          done_entry = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      if ((state_q == SET) && S && !R && !is_zero) begin
        state_d = RUN;
        presc_d = '0;
      end else if (key_ok) begin
        key_take = 1'b1;
        time_d   = '{min_tens: time_q.min_ones,
                     min_ones: time_q.sec_tens,
                     sec_tens: time_q.sec_ones,
                     sec_ones: key_digit};
        done_d   = 1'b0;
        state_d  = ({time_q.min_ones, time_q.sec_tens, time_q.sec_ones, key_digit}
                    != 16'h0000) ? SET : IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      time_q   <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
      mag_on_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      mag_on_q <= (state_d == RUN);
    end
  end

  assign mag_on     = mag_on_q;
  assign timer_done = done_q;
  assign min_tens   = time_q.min_tens;
  assign min_ones   = time_q.min_ones;
  assign sec_tens   = time_q.sec_tens;
  assign sec_ones   = time_q.sec_ones;

`ifdef DONE_BEEP_EN
  localparam int BEEP_CYCLES = BEEP_SECS * TICKS_PER_SEC;
  localparam int BEEP_W      = $clog2(BEEP_CYCLES + 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES - 1);

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              beep_q, beep_d;

  // Counter holds the number of high cycles still to come after this one.
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (clear || key_take) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (done_entry) begin
      beep_d     = 1'b1;
      beep_cnt_d = BEEP_LOAD;
    end else if (beep_q) begin
      if (beep_cnt_q == '0) begin
        beep_d = 1'b0;
      end else begin
        beep_cnt_d = beep_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule : microwave_timer
`default_nettype wire

// File: tb/tb_microwave_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microwave_timer
//  Purpose  : Self-checking bench for microwave_timer (TICKS_PER_SEC=4).
//             Directed scenarios followed by random stimulus, every cycle
//             compared against a behavioural model that keeps the time as
//             two integers (minutes field, seconds field).
//  Revision : 1.0  initial release
// ============================================================================
module tb_microwave_timer;

  localparam int T      = 4;
  localparam int BSECS  = 3;
  localparam int BEEP_N = BSECS * T;

  localparam int M_IDLE = 0;
  localparam int M_SET  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, S, R, clear, key_valid;
  logic [3:0] key_digit;
  logic       mag_on, timer_done, beep;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  int n_vec  = 0;
  int n_fail = 0;

  // model state
  int m_mm, m_ss, m_st, m_presc, m_done, m_beep_left;

  microwave_timer #(.TICKS_PER_SEC(T), .BEEP_SECS(BSECS)) dut (
    .clk        (clk),
    .rst        (rst),
    .S          (S),
    .R          (R),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
    .timer_done (timer_done),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the current inputs.
  task automatic model_edge();
    int d;
    if (m_beep_left > 0) m_beep_left--;
    if (rst) begin
      m_mm = 0; m_ss = 0; m_st = M_IDLE; m_presc = 0; m_done = 0; m_beep_left = 0;
    end else if (clear) begin
      m_mm = 0; m_ss = 0; m_st = M_IDLE; m_presc = 0; m_done = 0; m_beep_left = 0;
    end else if (m_st == M_RUN) begin
      if (R) begin
        m_st = M_SET;
      end else if (m_presc == T - 1) begin
        m_presc = 0;
        if (m_ss == 0) begin m_ss = 59; m_mm--; end
        else m_ss--;
        if (m_mm == 0 && m_ss == 0) begin
          m_st = M_DONE;
          m_done = 1;
          m_beep_left = BEEP_N;
        end
      end else begin
        m_presc++;
      end
    end else if (m_st == M_SET && S && !R && (m_mm * 100 + m_ss) != 0) begin
      m_st = M_RUN;
      m_presc = 0;
    end else if (key_valid && key_digit <= 9) begin
      d = ((m_mm * 100 + m_ss) * 10 + int'(key_digit)) % 10000;
      m_mm = d / 100;
      m_ss = d % 100;
      m_done = 0;
      m_beep_left = 0;
      m_st = (d != 0) ? M_SET : M_IDLE;
    end
  endtask

  task automatic compare_all();
    check_val("mag_on", 16'(mag_on), 16'(m_st == M_RUN));
    check_val("timer_done", 16'(timer_done), 16'(m_done));
    check_val("min_tens", 16'(min_tens), 16'(m_mm / 10));
    check_val("min_ones", 16'(min_ones), 16'(m_mm % 10));
    check_val("sec_tens", 16'(sec_tens), 16'(m_ss / 10));
    check_val("sec_ones", 16'(sec_ones), 16'(m_ss % 10));
`ifdef DONE_BEEP_EN
    check_val("beep", 16'(beep), 16'(m_beep_left > 0));
`else
    check_val("beep", 16'(beep), 16'd0);
`endif
  endtask

  task automatic step(input logic s, input logic r, input logic c,
                      input logic kv, input logic [3:0] kd, input logic rs);
    S = s; R = r; clear = c; key_valid = kv; key_digit = kd; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 0);
  endtask

  task automatic key(input logic [3:0] kd);
    step(0, 0, 0, 1, kd, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 1, 0, 4'd0, 0);
  endtask

  task automatic start();
    step(1, 0, 0, 0, 4'd0, 0);
  endtask

  int beep_cnt;

  initial begin
    m_mm = 0; m_ss = 0; m_st = M_IDLE; m_presc = 0; m_done = 0; m_beep_left = 0;
    S = 0; R = 0; clear = 0; key_valid = 0; key_digit = 0; rst = 1;

    // reset
    step(0, 0, 0, 0, 4'd0, 1);
    step(0, 0, 0, 0, 4'd0, 1);
    check_val("rst_mag_on", 16'(mag_on), 16'd0);
    check_val("rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

    // 00:15 full countdown
    key(4'd1); key(4'd5);
    check_val("load_15", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0015);
    start();
    check_val("s_to_mag_on", 16'(mag_on), 16'd1);
    idle(59);
    check_val("pre_done", 16'(timer_done), 16'd0);
    idle(1);
    check_val("done_flag", 16'(timer_done), 16'd1);
    check_val("done_mag_off", 16'(mag_on), 16'd0);
    check_val("done_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    idle(5);
    check_val("done_holds", 16'(timer_done), 16'd1);

    // 0:99 borrow from keypad-entered sec_tens
    do_clear();
    key(4'd9); key(4'd9);
    start();
    idle(40);
    check_val("run_0_99", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0089);
    idle(40 * 3);
    check_val("run_0_59", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);

    // 1:00 -> 0:59, pause, resume with prescaler restart
    do_clear();
    key(4'd1); key(4'd0); key(4'd0);
    start();
    idle(4);
    check_val("min_borrow", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    idle(2);
    step(0, 1, 0, 0, 4'd0, 0);
    check_val("pause_mag", 16'(mag_on), 16'd0);
    idle(20);
    check_val("pause_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    start();
    idle(3);
    check_val("resume_nt", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    idle(1);
    check_val("resume_tick", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0058);

    // ignored S / S+R / key in RUN / bad digit
    do_clear();
    start();
    check_val("s_at_zero", 16'(mag_on), 16'd0);
    key(4'd3);
    step(1, 1, 0, 0, 4'd0, 0);
    check_val("s_and_r", 16'(mag_on), 16'd0);
    start();
    key(4'd7);
    check_val("key_in_run", 16'(sec_ones), 16'd3);
    do_clear();
    key(4'd12);
    check_val("key_12", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

    // clear during RUN at 00:30
    key(4'd3); key(4'd0);
    start();
    idle(2);
    do_clear();
    check_val("clr_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check_val("clr_mag", 16'(mag_on), 16'd0);

    // rst mid-run
    key(4'd4); key(4'd2);
    start();
    idle(9);
    step(0, 0, 0, 0, 4'd0, 1);
    check_val("rst_run", {3'b000, mag_on, min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

    // beep length
    key(4'd1);
    start();
    beep_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      beep_cnt += int'(beep);
    end
`ifdef DONE_BEEP_EN
    check_val("beep_len", 16'(beep_cnt), 16'(BEEP_N));
`else
    check_val("beep_len", 16'(beep_cnt), 16'd0);
`endif

    // key entry mid-beep
    key(4'd1);
    start();
    idle(4 + 3);
    key(4'd4);
    check_val("key_beep_off", 16'(beep), 16'd0);
    check_val("key_done_off", 16'(timer_done), 16'd0);

    // random
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 511) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_microwave_timer
`default_nettype wire
